ffe_adapt_sequencer: RTL and testbench

Sequencer for the FFE tap estimator. It owns the estimator's `exec_inst`/`inst` command port and its `gain` input, and it serializes queued tap commands (load-init, shift-left, shift-right) into properly timed hold/release windows. It also runs a gear-shift schedule that steps the adaptation gain down from a start value to an end value. It sits between the configuration/JTAG register bank and the estimator inside the FIR adapter.

---
 rtl/ffe_adapt_sequencer_if.sv | 11 +
 rtl/ffe_adapt_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ffe_adapt_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ffe_adapt_sequencer_if.sv
// Command push bus into the FFE adaptation sequencer.
interface ffe_adapt_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_inst;

   // Producer side (config/JTAG register bank)
   modport master (output cmd_valid, output cmd_inst, input cmd_ready);
   // Consumer side (sequencer)
   modport slave  (input cmd_valid, input cmd_inst, output cmd_ready);
endinterface

// File: rtl/ffe_adapt_sequencer.sv
// FFE tap-estimator sequencer: queues tap commands, issues them as timed
// exec_inst hold/gap windows, and runs the adaptation gain gear schedule.
// Optional feature macro: FFE_ADAPT_SEQ_GEAR_EN (gear counter and gain stepping).
module ffe_adapt_sequencer #(
   parameter int unsigned adapt_bitwidth    = 14,
   parameter int unsigned cmd_depth         = 4,
   parameter int unsigned hold_cycles       = 4,
   parameter int unsigned gap_cycles        = 2,
   parameter int unsigned gear_cnt_bitwidth = 16,
   localparam int unsigned gain_w           = $clog2(adapt_bitwidth)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          adapt_en,
   ffe_adapt_sequencer_if.slave          cmd,
   input  logic [gain_w-1:0]             gain_start,
   input  logic [gain_w-1:0]             gain_end,
   input  logic [gear_cnt_bitwidth-1:0]  gear_period,
   output logic                          exec_inst,
   output logic [2:0]                    inst,
   output logic [gain_w-1:0]             gain,
   output logic                          busy,
   output logic                          gear_done
);

   localparam int unsigned ptr_w     = $clog2(cmd_depth);
   localparam int unsigned cnt_w     = ptr_w + 1;
   localparam int unsigned phase_max = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
   localparam int unsigned phase_w   = $clog2(phase_max);
   localparam int unsigned gear_w    = gear_cnt_bitwidth;

   localparam logic [2:0] inst_halt = 3'b000;
   localparam logic [2:0] inst_load = 3'b100;
   localparam logic [2:0] inst_shl  = 3'b011;
   localparam logic [2:0] inst_shr  = 3'b010;

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_adapt = 2'd1,
      st_hold  = 2'd2,
      st_gap   = 2'd3
   } state_t;

   state_t               state;
   state_t               state_d;
   logic [2:0]           mem [cmd_depth];
   logic [ptr_w-1:0]     wr_ptr;
   logic [ptr_w-1:0]     rd_ptr;
   logic [cnt_w-1:0]     count;
   logic [cnt_w-1:0]     count_d;
   logic [2:0]           cmd_q;
   logic [phase_w-1:0]   phase;
   logic                 cmd_ready_q;
   logic                 push;
   logic                 pop;
   logic                 empty;
   logic                 head_legal;
   logic [gain_w-1:0]    gain_d;
   logic                 exec_d;
   logic [2:0]           inst_d;
   logic                 busy_d;
   logic                 ready_d;
   logic                 gear_done_d;

   function automatic logic is_legal(input logic [2:0] c);
      return (c == inst_load) || (c == inst_shl) || (c == inst_shr);
   endfunction

   assign cmd.cmd_ready = cmd_ready_q;
   assign empty         = (count == '0);
   assign push          = cmd.cmd_valid && cmd_ready_q;
   assign pop           = (state == st_adapt) && !empty;
   assign head_legal    = is_legal(mem[rd_ptr]);
   assign count_d       = count + cnt_w'(push) - cnt_w'(pop);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= st_idle;
      else        state <= state_d;
   end

   // Next-state logic; a queued command outranks leaving ADAPT
   always_comb begin
      state_d = state;
      case (state)
         st_idle:  if (adapt_en) state_d = st_adapt;
         st_adapt: begin
            if (!empty) begin
               if (head_legal) state_d = st_hold;
            end else if (!adapt_en) begin
               state_d = st_idle;
            end
         end
         st_hold:  if (phase == phase_w'(hold_cycles - 1)) state_d = st_gap;
         st_gap:   if (phase == phase_w'(gap_cycles - 1))
                      state_d = adapt_en ? st_adapt : st_idle;
         default:  state_d = st_idle;
      endcase
   end

   // Output decode; exec/inst follow the current state one edge later
   always_comb begin
      exec_d  = 1'b0;
      inst_d  = inst_halt;
      case (state)
         st_idle: exec_d = 1'b1;
         st_hold: begin
            exec_d = 1'b1;
            inst_d = cmd_q;
         end
         default: ;
      endcase
      busy_d  = (state_d == st_hold) || (state_d == st_gap) || (count_d != '0);
      ready_d = (count_d != cnt_w'(cmd_depth));
`ifdef FFE_ADAPT_SEQ_GEAR_EN
      gear_done_d = (state_d == st_adapt) && (gain_d == gain_end);
`else
      gear_done_d = 1'b0;
`endif
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_inst   <= 1'b1;
         inst        <= inst_halt;
         busy        <= 1'b0;
         cmd_ready_q <= 1'b1;
         gear_done   <= 1'b0;
         gain        <= '0;
      end else begin
         exec_inst   <= exec_d;
         inst        <= inst_d;
         busy        <= busy_d;
         cmd_ready_q <= ready_d;
         gear_done   <= gear_done_d;
         gain        <= gain_d;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd.cmd_inst;
   end

   // FIFO pointers, command latch and hold/gap phase counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cmd_q  <= inst_halt;
         phase  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_w'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
         count <= count_d;
         if (pop && head_legal) cmd_q <= mem[rd_ptr];
         if ((state_d != state) || !((state == st_hold) || (state == st_gap)))
            phase <= '0;
         else
            phase <= phase + phase_w'(1);
      end
   end

`ifdef FFE_ADAPT_SEQ_GEAR_EN
   logic [gear_w-1:0] gear_cnt;
   logic [gear_w-1:0] gear_cnt_d;

   // Gear schedule: count idle ADAPT cycles, step gain down toward gain_end
   always_comb begin
      gain_d     = gain;
      gear_cnt_d = gear_cnt;
      if ((state == st_idle) && adapt_en) begin
         gain_d     = gain_start;
         gear_cnt_d = '0;
      end else if ((state == st_adapt) && empty && adapt_en && (gear_period != '0)) begin
         if (gear_cnt == (gear_period - gear_w'(1))) begin
            gear_cnt_d = '0;
            if (gain > gain_end) gain_d = gain - gain_w'(1);
         end else begin
            gear_cnt_d = gear_cnt + gear_w'(1);
         end
      end
   end

   // Gear counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gear_cnt <= '0;
      else        gear_cnt <= gear_cnt_d;
   end
`else
   logic unused_gear_cfg;
   assign unused_gear_cfg = ^{gain_end, gear_period};

   // Fixed gain: loaded on ADAPT entry only
   always_comb begin
      gain_d = gain;
      if ((state == st_idle) && adapt_en) gain_d = gain_start;
   end
`endif

endmodule

// File: tb/tb_ffe_adapt_sequencer.sv
// Self-checking bench for ffe_adapt_sequencer (default or FFE_ADAPT_SEQ_GEAR_EN build).
module tb_ffe_adapt_sequencer;

   localparam int unsigned depth  = 4;
   localparam int unsigned hold   = 4;
   localparam int unsigned gap    = 2;
`ifdef FFE_ADAPT_SEQ_GEAR_EN
   localparam bit gear_en = 1'b1;
`else
   localparam bit gear_en = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        adapt_en = 1'b0;
   logic [3:0]  gain_start = '0;
   logic [3:0]  gain_end = '0;
   logic [15:0] gear_period = '0;
   logic        exec_inst;
   logic [2:0]  inst;
   logic [3:0]  gain;
   logic        busy;
   logic        gear_done;

   ffe_adapt_sequencer_if cmd_bus ();

   ffe_adapt_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .adapt_en    (adapt_en),
      .cmd         (cmd_bus),
      .gain_start  (gain_start),
      .gain_end    (gain_end),
      .gear_period (gear_period),
      .exec_inst   (exec_inst),
      .inst        (inst),
      .gain        (gain),
      .busy        (busy),
      .gear_done   (gear_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: accepted command queue and expected per-cycle waveform
   logic [2:0] cmds[$];
   logic [2:0] q[$];
   bit         exp_exec [64];
   logic [2:0] exp_inst [64];
   bit         exp_busy [64];
   int         tl_len;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [2:0] c);
      return (c == 3'b100) || (c == 3'b011) || (c == 3'b010);
   endfunction

   // Expected waveform from the first ADAPT sample (index 0) onwards:
   // a legal command popped at index t is held on samples t+1..t+hold, and the
   // next pop happens hold+gap+1 later; an illegal one only costs one pop slot.
   function automatic void build_timeline();
      int t;
      int busy_end;
      for (int i = 0; i < 64; i++) begin
         exp_exec[i] = 1'b0;
         exp_inst[i] = 3'b000;
         exp_busy[i] = 1'b0;
      end
      exp_exec[0] = 1'b1;
      t = 1;
      busy_end = 1;
      foreach (q[n]) begin
         if (legal(q[n])) begin
            for (int j = 1; j <= int'(hold); j++) begin
               exp_exec[t + j] = 1'b1;
               exp_inst[t + j] = q[n];
            end
            busy_end = t + int'(hold) + int'(gap);
            t = t + int'(hold) + int'(gap) + 1;
         end else begin
            busy_end = t;
            t = t + 1;
         end
      end
      for (int i = 0; i < busy_end; i++) exp_busy[i] = 1'b1;
      tl_len = t + 2;
   endfunction

   // Push cmds while IDLE, release adapt_en, compare the issued window sequence
   task automatic run_batch();
      q.delete();
      gain_start  = 4'($urandom_range(1, 15));
      gain_end    = 4'($urandom_range(0, int'(gain_start) - 1));
      gear_period = '0;
      foreach (cmds[n]) begin
         check("cmd_ready", 16'(cmd_bus.cmd_ready), 16'(q.size() != depth));
         cmd_bus.cmd_valid = 1'b1;
         cmd_bus.cmd_inst  = cmds[n];
         @(posedge clk);
         if (q.size() < depth) q.push_back(cmds[n]);
         #1;
      end
      cmd_bus.cmd_valid = 1'b0;
      build_timeline();
      adapt_en = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k <= tl_len; k++) begin
         check($sformatf("exec_inst[%0d]", k), 16'(exec_inst), 16'(exp_exec[k]));
         check($sformatf("inst[%0d]", k), 16'(inst), 16'(exp_inst[k]));
         check($sformatf("busy[%0d]", k), 16'(busy), 16'(exp_busy[k]));
         check($sformatf("gain[%0d]", k), 16'(gain), 16'(gain_start));
         check($sformatf("gear_done[%0d]", k), 16'(gear_done), 16'd0);
         @(posedge clk);
         #1;
      end
      adapt_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_exec", 16'(exec_inst), 16'd1);
      check("idle_busy", 16'(busy), 16'd0);
   endtask

   initial begin
      int n;
      int active;
      int paused;
      int exp_gain;
      logic [2:0] c;

      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_inst  = 3'b000;

      // Reset values, during and after reset
      #12;
      check("rst_exec", 16'(exec_inst), 16'd1);
      check("rst_inst", 16'(inst), 16'd0);
      check("rst_ready", 16'(cmd_bus.cmd_ready), 16'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("hold_exec", 16'(exec_inst), 16'd1);
         check("hold_inst", 16'(inst), 16'd0);
         check("hold_gain", 16'(gain), 16'd0);
         check("hold_ready", 16'(cmd_bus.cmd_ready), 16'd1);
         check("hold_busy", 16'(busy), 16'd0);
         check("hold_gear_done", 16'(gear_done), 16'd0);
      end

      // Single load-init command
      cmds.delete();
      cmds.push_back(3'b100);
      run_batch();

      // Five pushes into a depth-4 FIFO: the fifth is refused
      cmds.delete();
      cmds.push_back(3'b100);
      cmds.push_back(3'b011);
      cmds.push_back(3'b010);
      cmds.push_back(3'b100);
      cmds.push_back(3'b011);
      run_batch();

      // Illegal command between two legal ones
      cmds.delete();
      cmds.push_back(3'b011);
      cmds.push_back(3'b111);
      cmds.push_back(3'b010);
      run_batch();

      // Randomized batches, legal and illegal mix
      repeat (8) begin
         cmds.delete();
         n = $urandom_range(1, depth + 1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 7) begin
               case ($urandom_range(0, 2))
                  0:       c = 3'b100;
                  1:       c = 3'b011;
                  default: c = 3'b010;
               endcase
            end else begin
               c = 3'($urandom_range(0, 7));
               while (legal(c)) c = 3'($urandom_range(0, 7));
            end
            cmds.push_back(c);
         end
         run_batch();
      end

      // Push latency in ADAPT with empty FIFO: exec rises two edges after the push
      adapt_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_inst  = 3'b010;
      @(posedge clk);
      #1;
      cmd_bus.cmd_valid = 1'b0;
      check("lat_exec_n0", 16'(exec_inst), 16'd0);
      @(posedge clk);
      #1;
      check("lat_exec_n1", 16'(exec_inst), 16'd0);
      @(posedge clk);
      #1;
      check("lat_exec_n2", 16'(exec_inst), 16'd1);
      check("lat_inst_n2", 16'(inst), 16'b010);
      repeat (10) @(posedge clk);
      #1;
      adapt_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Gear schedule 8 -> 5 every 100 cycles, with a command at sample 150
      gain_start  = 4'd8;
      gain_end    = 4'd5;
      gear_period = 16'd100;
      adapt_en    = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k <= 420; k++) begin
         paused = (k < 152) ? 0 : (((k < 158) ? k : 158) - 151);
         active = k - paused;
         exp_gain = gear_en ? ((8 - active / 100 > 5) ? 8 - active / 100 : 5) : 8;
         check($sformatf("gear_gain[%0d]", k), 16'(gain), 16'(exp_gain));
         check($sformatf("gear_done[%0d]", k), 16'(gear_done),
               16'(gear_en && (exp_gain == 5) && !(k >= 152 && k <= 157)));
         if (k == 150) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_inst  = 3'b100;
         end
         @(posedge clk);
         #1;
         cmd_bus.cmd_valid = 1'b0;
      end
      adapt_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset during HOLD with commands still queued
      gear_period = '0;
      for (int i = 0; i < 3; i++) begin
         cmd_bus.cmd_valid = 1'b1;
         cmd_bus.cmd_inst  = (i == 1) ? 3'b011 : 3'b100;
         @(posedge clk);
         #1;
      end
      cmd_bus.cmd_valid = 1'b0;
      adapt_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_exec", 16'(exec_inst), 16'd1);
      check("pre_rst_inst", 16'(inst), 16'b100);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_exec", 16'(exec_inst), 16'd1);
      check("mid_rst_inst", 16'(inst), 16'd0);
      check("mid_rst_busy", 16'(busy), 16'd0);
      check("mid_rst_ready", 16'(cmd_bus.cmd_ready), 16'd1);
      check("mid_rst_gain", 16'(gain), 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst_inst[%0d]", k), 16'(inst), 16'd0);
         check($sformatf("post_rst_busy[%0d]", k), 16'(busy), 16'd0);
      end
      adapt_en = 1'b0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
